trash_fetch: RTL and testbench

Program store and instruction fetch stage sitting directly upstream of the trash execute core. It captures 15-bit instruction words into an 8-entry program memory during load, then sequences a program counter. Each stored word is presented to the execute stage over a valid/ready handshake, and the execute stage can redirect the counter with jumps.

---
 rtl/trash_fetch.sv | 139 +++++++++++++
 tb/tb_trash_fetch.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/trash_fetch.sv
// Program store and instruction fetch for the trash execute core: loads up to
// PROG_DEPTH words, then sequences a pc and issues words over valid/ready.
module trash_fetch #(
   parameter int PROG_DEPTH = 8,
   parameter int ADDR_W     = 3,
   parameter int INSTR_W    = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_en,
   input  logic               load_valid,
   input  logic [INSTR_W-1:0] load_data,
   input  logic               run,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               jump_en,
   input  logic [ADDR_W-1:0]  jump_addr,
   output logic [ADDR_W-1:0]  pc,
   output logic [ADDR_W:0]    prog_count,
   output logic               prog_full,
   output logic               overflow,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, LOAD, FETCH, ISSUE} state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d, wr_ptr_q, wr_ptr_d, pc_next;
   logic [ADDR_W:0]      count_q, count_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic                 vld_q, vld_d, ovf_q, ovf_d;
   logic                 mem_we, full, accept;
   logic [INSTR_W-1:0]   mem [PROG_DEPTH];

   assign full   = (count_q == (ADDR_W+1)'(PROG_DEPTH));
   assign accept = vld_q & instr_ready;

   // Out-of-range jump targets restart the program rather than run stale words.
   always_comb begin
      pc_next = pc_q + 1'b1;
      if (jump_en) begin
         pc_next = ({1'b0, jump_addr} < count_q) ? jump_addr : '0;
      end else if ({1'b0, pc_q} == count_q - 1'b1) begin
         pc_next = '0;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      instr_d  = instr_q;
      vld_d    = vld_q;
      ovf_d    = ovf_q;
      mem_we   = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_en) begin
               state_d  = LOAD;
               wr_ptr_d = '0;
               count_d  = '0;
               ovf_d    = 1'b0;
            end else if (run && count_q != '0) begin
               state_d = FETCH;
               pc_d    = '0;
            end
         end
         LOAD: begin
            if (load_valid) begin
               if (!full) begin
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  count_d  = count_q + 1'b1;
               end else begin
                  ovf_d = 1'b1;
               end
            end
            if (!load_en) state_d = IDLE;
         end
         FETCH: begin
            if (run) begin
               instr_d = mem[pc_q];
               vld_d   = 1'b1;
               state_d = ISSUE;
            end else begin
               vld_d   = 1'b0;
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (accept) begin
               vld_d   = 1'b0;
               pc_d    = pc_next;
               state_d = run ? FETCH : IDLE;
            end else if (!run) begin
               vld_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         instr_q  <= '0;
         vld_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         instr_q  <= instr_d;
         vld_q    <= vld_d;
         ovf_q    <= ovf_d;
      end
   end

   // Program storage carries no reset; prog_count alone marks what is valid.
   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_ptr_q] <= load_data;
   end

   assign instr       = instr_q;
   assign instr_valid = vld_q;
   assign pc          = pc_q;
   assign prog_count  = count_q;
   assign prog_full   = full;
   assign overflow    = ovf_q;
   assign busy        = (state_q == FETCH) || (state_q == ISSUE);

endmodule

// File: tb/tb_trash_fetch.sv
// Directed bench for trash_fetch with an issue scoreboard fed from a program model.
module tb_trash_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_en, load_valid, run, instr_ready, jump_en;
   logic [14:0] load_data;
   logic [2:0]  jump_addr;
   logic [14:0] instr;
   logic        instr_valid, prog_full, overflow, busy;
   logic [2:0]  pc;
   logic [3:0]  prog_count;

   int          vectors = 0;
   int          errors  = 0;
   logic [14:0] mmem [8];
   int          mcount = 0;
   logic [17:0] sb [$];

   trash_fetch #(.PROG_DEPTH(8), .ADDR_W(3), .INSTR_W(15)) dut (
      .clk(clk), .reset(reset), .load_en(load_en), .load_valid(load_valid),
      .load_data(load_data), .run(run), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .jump_en(jump_en), .jump_addr(jump_addr), .pc(pc),
      .prog_count(prog_count), .prog_full(prog_full), .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load_begin();
      load_en = 1'b1;
      tick();
      mcount = 0;
   endtask

   task automatic load_word(input logic [14:0] d);
      load_valid = 1'b1;
      load_data  = d;
      tick();
      load_valid = 1'b0;
      if (mcount < 8) begin
         mmem[mcount] = d;
         mcount++;
      end
   endtask

   task automatic load_end();
      load_en = 1'b0;
      tick();
   endtask

   // Expects one accept/fetch gap cycle, then the word at exp_pc on the bus.
   task automatic step_issue(input int exp_pc, input logic j, input logic [2:0] ja);
      logic [17:0] e;
      sb.push_back({3'(exp_pc), mmem[exp_pc]});
      jump_en   = j;
      jump_addr = ja;
      tick();
      jump_en = 1'b0;
      check("gap_valid", 32'(instr_valid), 32'd0);
      tick();
      check("issue_valid", 32'(instr_valid), 32'd1);
      check("sb_depth", 32'(sb.size()), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("issue_pc", 32'(pc), 32'(e[17:15]));
         check("issue_instr", 32'(instr), 32'(e[14:0]));
      end
   endtask

   initial begin
      reset = 1'b1; load_en = 1'b0; load_valid = 1'b0; load_data = '0;
      run = 1'b0; instr_ready = 1'b0; jump_en = 1'b0; jump_addr = '0;
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_count", 32'(prog_count), 32'd0);
      check("rst_instr", 32'(instr), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      tick();

      // Empty program: run must not start fetching
      run = 1'b1;
      tick(); tick();
      check("empty_busy", 32'(busy), 32'd0);
      check("empty_valid", 32'(instr_valid), 32'd0);
      run = 1'b0;

      // Three-word program, back-to-back accepts with wrap
      load_begin();
      load_word(15'h1A5F); load_word(15'h2003); load_word(15'h3C01);
      load_end();
      check("t1_count", 32'(prog_count), 32'd3);
      run = 1'b1; instr_ready = 1'b1;
      step_issue(0, 1'b0, 3'd0);
      step_issue(1, 1'b0, 3'd0);
      step_issue(2, 1'b0, 3'd0);
      step_issue(0, 1'b0, 3'd0);
      run = 1'b0;
      tick();
      check("t1_stop_busy", 32'(busy), 32'd0);
      check("t1_stop_valid", 32'(instr_valid), 32'd0);
      check("t1_stop_pc", 32'(pc), 32'd1);

      // Fill, overflow, then replay all eight entries
      load_begin();
      for (int i = 0; i < 8; i++) load_word(15'(16'h0A00 + i * 16'h0931));
      check("t2_full", 32'(prog_full), 32'd1);
      check("t2_ovf_pre", 32'(overflow), 32'd0);
      load_word(15'h7FFF); load_word(15'h5555);
      check("t2_ovf", 32'(overflow), 32'd1);
      check("t2_count", 32'(prog_count), 32'd8);
      load_end();
      run = 1'b1;
      for (int i = 0; i < 8; i++) step_issue(i, 1'b0, 3'd0);
      step_issue(0, 1'b0, 3'd0);
      run = 1'b0;
      tick();
      check("t2_idle", 32'(busy), 32'd0);
      load_begin();
      check("t2_reload_ovf", 32'(overflow), 32'd0);
      check("t2_reload_count", 32'(prog_count), 32'd0);

      // Four-word program with backpressure on pc=2
      for (int i = 0; i < 4; i++) load_word(15'(16'h3100 + i * 16'h0207));
      load_end();
      run = 1'b1;
      step_issue(0, 1'b0, 3'd0);
      step_issue(1, 1'b0, 3'd0);
      step_issue(2, 1'b0, 3'd0);
      instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t3_hold_valid", 32'(instr_valid), 32'd1);
         check("t3_hold_pc", 32'(pc), 32'd2);
         check("t3_hold_instr", 32'(instr), 32'(mmem[2]));
      end
      instr_ready = 1'b1;
      step_issue(3, 1'b0, 3'd0);
      step_issue(0, 1'b0, 3'd0);

      // Jumps: in range, out of range, and without accept
      step_issue(1, 1'b0, 3'd0);
      step_issue(3, 1'b1, 3'd3);
      step_issue(0, 1'b1, 3'd6);
      instr_ready = 1'b0; jump_en = 1'b1; jump_addr = 3'd2;
      tick(); tick();
      check("t4_nojump_pc", 32'(pc), 32'd0);
      check("t4_nojump_valid", 32'(instr_valid), 32'd1);
      jump_en = 1'b0; instr_ready = 1'b1;
      step_issue(1, 1'b0, 3'd0);

      // load_en ignored while busy, then withdrawal on run drop
      instr_ready = 1'b0; load_en = 1'b1;
      tick(); tick();
      check("t5_count", 32'(prog_count), 32'd4);
      check("t5_busy", 32'(busy), 32'd1);
      check("t5_valid", 32'(instr_valid), 32'd1);
      load_en = 1'b0; run = 1'b0;
      tick();
      check("t5_wd_valid", 32'(instr_valid), 32'd0);
      check("t5_wd_busy", 32'(busy), 32'd0);
      check("t5_wd_pc", 32'(pc), 32'd1);

      // Asynchronous reset in the middle of ISSUE
      run = 1'b1; instr_ready = 1'b1;
      step_issue(0, 1'b0, 3'd0);
      step_issue(1, 1'b0, 3'd0);
      instr_ready = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("t6_valid", 32'(instr_valid), 32'd0);
      check("t6_pc", 32'(pc), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_count", 32'(prog_count), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick(); tick();
      check("t6_norun_busy", 32'(busy), 32'd0);
      check("t6_norun_valid", 32'(instr_valid), 32'd0);
      run = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
